esdi_serial_responder: RTL
==========================

# esdi_serial_responder

Drive-side end of the ESDI serial command/status channel, for drive emulation and loopback testing of the host controller. Receives 17-bit command frames bit by bit over the TRANSFER REQ / TRANSFER ACK handshake and hands each good command to a local drive model. It returns 17-bit status/configuration frames on CONFIG/STATUS DATA and drives COMMAND COMPLETE and ATTENTION. All ESDI-side signals are logical active-high; pad inversion is handled at chip top level.

## Interface
- SYNC_STAGES, 2, flops per input synchronizer (≥2)
- SETUP_CYCLES, 4, clocks confstat_data is stable before ack rises (≥1)
- BIT_TIMEOUT, 50000, clocks allowed waiting for next req mid-frame (16-bit counter)

- clk  in  1  sole clock
- resetn  in  1  synchronous, active-low reset
- esdi_transfer_req  in  1  host bit strobe, asynchronous
- esdi_command_data  in  1  host command bit, asynchronous
- esdi_transfer_ack  out  1  bit handshake acknowledge
- esdi_confstat_data  out  1  status/config bit to host
- esdi_command_complete  out  1  high = idle, ready for command
- esdi_attention  out  1  high = error latched
- cmd_valid  out  1  one-cycle pulse, good command received
- cmd_word  out  16  received command; held until next cmd_valid
- cmd_needs_data  out  1  opcode cmd_word[15:12] is 0x0 (status) or 0x1 (config)
- exec_done  in  1  drive model finished current command
- exec_status  in  16  response word, sampled with exec_done
- parity_err  out  1  one-cycle pulse on bad frame parity
- busy  out  1  high in any state other than IDLE

## Operation
- Frame: bit 15 first down to bit 0, then parity bit; odd parity over all 17 bits (parity = ~^word).
- States: IDLE, RX_REQ, RX_REL, CHECK, EXEC, TX_SETUP, TX_REL, TX_REQ, DONE.
- IDLE/RX_REQ: on synchronized req high, shift synchronized command_data into the 17-bit register, set ack, go to RX_REL. RX_REL: on req low, clear ack, increment bit count. Count 17 goes to CHECK; otherwise RX_REQ.
- CHECK, good parity: cmd_valid pulse, attention cleared, command_complete low, go to EXEC.
- CHECK, bad parity: parity_err pulse, attention set, command_complete stays high, no cmd_valid, return to IDLE.
- EXEC: exec_done is honoured only here, from the cycle after cmd_valid. When exec_done arrives:
  - cmd_needs_data: latch exec_status into the TX shifter and go to TX_REQ.
  - otherwise: go to DONE.
- TX_REQ: on req high, drive the next bit on confstat_data and go to TX_SETUP. TX_SETUP: count SETUP_CYCLES, then set ack and go to TX_REL. TX_REL: on req low, clear ack. After 17 bits go to DONE; otherwise TX_REQ.
- DONE: command_complete high, confstat_data 0, go to IDLE.
- Timeout: in RX_REQ with bit count > 0, or in TX_REQ, req low for BIT_TIMEOUT consecutive clocks:
  - discard the frame, set attention, ack low, command_complete high, go to IDLE.
- exec_done outside EXEC is ignored. A req change while ack is pending has no effect until the current phase completes.

## Timing
- Inputs pass through SYNC_STAGES flops; req and data are synchronized identically, so they stay aligned.
- RX ack rises 1 clock after synchronized req is seen high, i.e. SYNC_STAGES+1 clocks after the pin. Ack falls 1 clock after synchronized req is seen low.
- cmd_valid: 1 clock after the 17th ack falls.
- TX: confstat_data changes, then ack rises exactly SETUP_CYCLES clocks later.
- Reset values: ack 0, confstat_data 0, command_complete 1, attention 0, cmd_valid 0, cmd_word 0, parity_err 0, busy 0.
- Reset asserted mid-frame returns every output to its reset value at the next edge and discards the partial frame.

## Structure
- Package esdi_pkg holds:
  - state enum
  - FRAME_BITS=17
  - OP_REQ_STATUS=4'h0, OP_REQ_CONFIG=4'h1
  - odd-parity function
- Sub-module esdi_sync (parameterized flop-chain synchronizer), instantiated for req and command_data.

## Test plan
- Send 0x0000 with parity 1 → cmd_valid, cmd_word 0x0000, cmd_needs_data 1, command_complete low. Then exec_done with exec_status 0xA5C3 → confstat bits 1010010111000011 followed by parity 1, then command_complete high.
- Send 0x2001 with parity 1, then exec_done → no TX handshakes; command_complete high 2 clocks after exec_done.
- Send 0x0000 with parity 0 → parity_err pulse, attention 1, no cmd_valid. A following good 0x2001 clears attention.
- BIT_TIMEOUT=100: send 5 bits, then hold req low for 100 clocks → IDLE, attention 1, ack 0. The next full 0x1000 frame (parity 0) is decoded correctly.
- Resetn low after 8 TX bits → all outputs at reset values next edge. A new 0x0000 frame then works normally.
- Assert exec_done while IDLE → ignored. Every TX bit: ack rises exactly SETUP_CYCLES clocks after confstat_data changes.

Source files
------------

// File: rtl/esdi_pkg.sv
// Shared types and constants for the ESDI serial command/status responder.
package esdi_pkg;

    localparam int FRAME_BITS = 17;

    localparam logic [3:0] OP_REQ_STATUS = 4'h0;
    localparam logic [3:0] OP_REQ_CONFIG = 4'h1;

    typedef enum logic [3:0] {
        S_IDLE,
        S_RX_REQ,
        S_RX_REL,
        S_CHECK,
        S_EXEC,
        S_TX_SETUP,
        S_TX_REL,
        S_TX_REQ,
        S_DONE
    } state_t;

    // Parity bit that makes the 17-bit frame contain an odd number of ones.
    function automatic logic odd_parity(input logic [15:0] word);
        return ~^word;
    endfunction

endpackage

// File: rtl/esdi_sync.sv
// Flop-chain synchronizer for one asynchronous ESDI input.
module esdi_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic resetn,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    // NOTE: reset is sampled inside the clocked block, so it only acts on an edge.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/esdi_serial_responder.sv
// Drive-side ESDI serial channel: receives 17-bit commands over the REQ/ACK
// handshake and returns 17-bit status/config frames for the local drive model.
module esdi_serial_responder
    import esdi_pkg::*;
#(
    parameter int SYNC_STAGES  = 2,
    parameter int SETUP_CYCLES = 4,
    parameter int BIT_TIMEOUT  = 50000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        esdi_transfer_req,
    input  logic        esdi_command_data,
    output logic        esdi_transfer_ack,
    output logic        esdi_confstat_data,
    output logic        esdi_command_complete,
    output logic        esdi_attention,
    output logic        cmd_valid,
    output logic [15:0] cmd_word,
    output logic        cmd_needs_data,
    input  logic        exec_done,
    input  logic [15:0] exec_status,
    output logic        parity_err,
    output logic        busy
);

    localparam int SC_W = $clog2(SETUP_CYCLES) + 1;
    localparam logic [SC_W-1:0] SETUP_LAST   = SC_W'(SETUP_CYCLES - 1);
    localparam logic [15:0]     TIMEOUT_LAST = 16'(BIT_TIMEOUT - 1);
    localparam logic [4:0]      LAST_BIT     = 5'(FRAME_BITS - 1);

    logic req_s, data_s;

    esdi_sync #(.STAGES(SYNC_STAGES)) u_sync_req (
        .clk(clk), .resetn(resetn), .d(esdi_transfer_req), .q(req_s)
    );
    esdi_sync #(.STAGES(SYNC_STAGES)) u_sync_data (
        .clk(clk), .resetn(resetn), .d(esdi_command_data), .q(data_s)
    );

    state_t            state;
    logic [16:0]       rx_shift;
    logic [16:0]       tx_shift;
    logic [4:0]        bit_cnt;
    logic [SC_W-1:0]   setup_cnt;
    logic [15:0]       timeout_cnt;
    logic              timeout_armed;
    logic              timeout_hit;

    // Only a host stall mid-frame is timed; an idle channel may wait forever.
    assign timeout_armed = (state == S_RX_REQ && bit_cnt != 5'd0) || (state == S_TX_REQ);
    assign timeout_hit   = timeout_armed && !req_s && (timeout_cnt == TIMEOUT_LAST);

    assign busy           = (state != S_IDLE);
    assign cmd_needs_data = (cmd_word[15:12] == OP_REQ_STATUS) ||
                            (cmd_word[15:12] == OP_REQ_CONFIG);

    // NOTE: all state here is updated with <= so every branch reads pre-edge values.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state                 <= S_IDLE;
            rx_shift              <= '0;
            tx_shift              <= '0;
            bit_cnt               <= '0;
            setup_cnt             <= '0;
            timeout_cnt           <= '0;
            esdi_transfer_ack     <= 1'b0;
            esdi_confstat_data    <= 1'b0;
            esdi_command_complete <= 1'b1;
            esdi_attention        <= 1'b0;
            cmd_valid             <= 1'b0;
            cmd_word              <= '0;
            parity_err            <= 1'b0;
        end else begin
            cmd_valid  <= 1'b0;
            parity_err <= 1'b0;

            if (timeout_armed && !req_s) begin
                timeout_cnt <= timeout_cnt + 16'd1;
            end else begin
                timeout_cnt <= '0;
            end

            if (timeout_hit) begin
                state                 <= S_IDLE;
                bit_cnt               <= '0;
                esdi_attention        <= 1'b1;
                esdi_transfer_ack     <= 1'b0;
                esdi_confstat_data    <= 1'b0;
                esdi_command_complete <= 1'b1;
            end else begin
                case (state)
                    S_IDLE, S_RX_REQ: begin
                        if (req_s) begin
                            rx_shift          <= {rx_shift[15:0], data_s};
                            esdi_transfer_ack <= 1'b1;
                            state             <= S_RX_REL;
                        end
                    end
                    S_RX_REL: begin
                        if (!req_s) begin
                            esdi_transfer_ack <= 1'b0;
                            bit_cnt           <= bit_cnt + 5'd1;
                            state             <= (bit_cnt == LAST_BIT) ? S_CHECK : S_RX_REQ;
                        end
                    end
                    S_CHECK: begin
                        bit_cnt <= '0;
                        if (odd_parity(rx_shift[16:1]) == rx_shift[0]) begin
                            cmd_valid             <= 1'b1;
                            cmd_word              <= rx_shift[16:1];
                            esdi_attention        <= 1'b0;
                            esdi_command_complete <= 1'b0;
                            state                 <= S_EXEC;
                        end else begin
                            parity_err     <= 1'b1;
                            esdi_attention <= 1'b1;
                            state          <= S_IDLE;
                        end
                    end
                    S_EXEC: begin
                        // cmd_valid still high means the drive model has not seen the command yet.
                        if (exec_done && !cmd_valid) begin
                            if (cmd_needs_data) begin
                                tx_shift <= {exec_status, odd_parity(exec_status)};
                                state    <= S_TX_REQ;
                            end else begin
                                state <= S_DONE;
                            end
                        end
                    end
                    S_TX_REQ: begin
                        if (req_s) begin
                            esdi_confstat_data <= tx_shift[16];
                            tx_shift           <= {tx_shift[15:0], 1'b0};
                            setup_cnt          <= '0;
                            state              <= S_TX_SETUP;
                        end
                    end
                    S_TX_SETUP: begin
                        if (setup_cnt == SETUP_LAST) begin
                            esdi_transfer_ack <= 1'b1;
                            state             <= S_TX_REL;
                        end else begin
                            setup_cnt <= setup_cnt + 1'b1;
                        end
                    end
                    S_TX_REL: begin
                        if (!req_s) begin
                            esdi_transfer_ack <= 1'b0;
                            bit_cnt           <= bit_cnt + 5'd1;
                            state             <= (bit_cnt == LAST_BIT) ? S_DONE : S_TX_REQ;
                        end
                    end
                    S_DONE: begin
                        esdi_command_complete <= 1'b1;
                        esdi_confstat_data    <= 1'b0;
                        esdi_transfer_ack     <= 1'b0;
                        bit_cnt               <= '0;
                        state                 <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
